// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// Defining UART_TX_PARITY_EN adds an even-parity symbol to each frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_SYMBOLS = 11;
`else
  localparam int FRAME_SYMBOLS = 10;
`endif

  // Cycles per symbol; integer truncation of the clock/baud ratio.
  function automatic int symbol_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Symbol-period counter with synchronous clear; o_tick is high on the last
// cycle of each period. START_COUNT lets the receiver start at a half period.
module uart_baud_tick #(
  parameter int PERIOD      = 434,
  parameter int WIDTH       = 9,
  parameter int START_COUNT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  logic [WIDTH-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_count == WIDTH'(PERIOD - 1));
  assign o_tick = w_tick;

  // Period counter: wraps to zero at each symbol boundary.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= WIDTH'(START_COUNT);
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a ready/valid byte input and registered line output.
// Defining UART_TX_PARITY_EN inserts an even-parity symbol before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = symbol_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

  if (SYMBOL_EDGE_TIME < 2) begin : g_symbol_time_guard
    $error("uart_transmitter: SYMBOL_EDGE_TIME must be at least 2");
  end

  uart_state_e r_state, w_next_state;
  logic [7:0]  r_shift, w_next_shift;
  logic [3:0]  r_bit_cnt, w_next_bit_cnt;
  logic        r_serial_out, w_next_serial;
  logic        r_ready;
  logic        w_tick, w_accept;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_accept      = data_in_valid && r_ready;
  assign data_in_ready = r_ready;
  assign serial_out    = r_serial_out;

  // The counter is held at zero while idle so each frame starts on a clean symbol.
  uart_baud_tick #(
    .PERIOD      (SYMBOL_EDGE_TIME),
    .WIDTH       (CLOCK_COUNTER_WIDTH),
    .START_COUNT (0)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == IDLE),
    .o_tick  (w_tick)
  );

  // Next-state, shift and bit-count logic.
  always_comb begin
    w_next_state   = r_state;
    w_next_shift   = r_shift;
    w_next_bit_cnt = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state   = START;
          w_next_shift   = data_in;
          w_next_bit_cnt = 4'd0;
        end else begin
          w_next_state = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_next_state = DATA;
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_next_shift = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
            w_next_bit_cnt = 4'd0;
`ifdef UART_TX_PARITY_EN
            w_next_state   = PARITY;
`else
            w_next_state   = STOP;
`endif
          end else begin
            w_next_bit_cnt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_next_state = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_next_state = STOP;
        end else begin
          w_next_state = PARITY;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so the register updates with the FSM.
  always_comb begin
    w_next_serial = 1'b1;
    case (w_next_state)
      IDLE:    w_next_serial = 1'b1;
      START:   w_next_serial = 1'b0;
      DATA:    w_next_serial = w_next_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_next_serial = r_parity;
`endif
      STOP:    w_next_serial = 1'b1;
      default: w_next_serial = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 4'd0;
      r_serial_out <= 1'b1;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_shift      <= w_next_shift;
      r_bit_cnt    <= w_next_bit_cnt;
      r_serial_out <= w_next_serial;
      r_ready      <= (w_next_state == IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, captured alongside the shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^data_in;
    end else begin
      r_parity <= r_parity;
    end
  end
`endif

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializes bytes onto an asynchronous 8N1 serial line; idle-high, LSB first.
- Line-side counterpart to the CPU's serial receive path. Drives the line that feeds FPGA_SERIAL_RX, for the host-side loader and bench, and for the CPU's own TX path.
- Byte input is a ready/valid handshake from the MMIO/loader logic.
- Runs in the 50 MHz MMCM clock domain alongside Riscv151.

Parameters:
- CLOCK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- Derived localparam SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer truncation; 434 at the defaults.
- Derived localparam CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  block can accept a byte this cycle.
- serial_out  output  1  serial line, idle high.

Behaviour:
- Interface rule (fixed): one clock, clk; reset is synchronous and active-high, on port rst.
- Reset values: serial_out=1, data_in_ready=1, state=IDLE, bit counter=0, clock counter=0, shift register=0.
- Reset mid-frame: the frame aborts. serial_out=1 and data_in_ready=1 from the cycle after the reset edge. A partial frame is never resumed.
- Handshake:
  - A byte is accepted on a rising edge where data_in_valid && data_in_ready.
  - data_in is captured into the shift register on that edge.
  - data_in_ready is high only in IDLE. It drops the cycle after acceptance.
  - data_in_valid while not ready is ignored; no buffering.
- States:
  - IDLE: serial_out=1; on accept, go to START.
  - START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA.
  - DATA: serial_out=shift[0]. Each bit is held for SYMBOL_EDGE_TIME cycles, then the register shifts right. After 8 bits, go to STOP (or PARITY when enabled).
  - STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles, then go to IDLE.
- Timing:
  - Latency: serial_out falls on the edge immediately after acceptance; one-cycle register delay.
  - Every symbol is exactly SYMBOL_EDGE_TIME cycles. The clock counter runs 0..SYMBOL_EDGE_TIME-1 and wraps to 0 at each symbol boundary.
  - Back-to-back: with data_in_valid held high, consecutive start-bit falling edges are 10*SYMBOL_EDGE_TIME+1 cycles apart (one IDLE cycle between frames).
- Width rules: the bit counter is 4 bits; comparisons use unsigned widths.
- Elaboration guard: SYMBOL_EDGE_TIME < 2 is an elaboration error, reported with $error.
- Glitch-free output: serial_out is a registered output. It never toggles except at symbol boundaries.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for SYMBOL_EDGE_TIME cycles.
  - Frame is 11 symbols; back-to-back spacing is 11*SYMBOL_EDGE_TIME+1 cycles.
- Undefined:
  - The PARITY state and the parity register are absent.
  - Frame is 8N1, 10 symbols.

Decomposition:
- Package uart_pkg holds:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - FRAME_SYMBOLS constant, 10 or 11 depending on UART_TX_PARITY_EN;
  - the symbol-time derivation function, shared with the receiver.
- One sub-module is natural: uart_baud_tick.
  - Parameterized counter with synchronous clear.
  - Emits a 1-cycle tick at each symbol boundary.
  - Reused by the receiver, which instantiates it with a half-period offset.

Test Plan:
- Reset: hold rst 3 cycles, then release -> serial_out=1 and data_in_ready=1 on the first post-reset cycle; line stays high for 1000 idle cycles.
- Single byte: send 8'hA5 at defaults. Expected response:
  - serial_out falls 1 cycle after accept;
  - bits sampled at mid-symbol (217+434n cycles) read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop);
  - data_in_ready returns high after 4340 cycles.
- Back-to-back: keep data_in_valid high with 8'h00 then 8'hFF -> start edges exactly 4341 cycles apart; a bench receiver decodes 00, FF.
- Ignored input: pulse data_in_valid with 8'h3C mid-frame while data_in_ready=0 -> no effect on the current frame; byte never sent.
- Reset mid-frame: assert rst during data bit 3 of 8'h0F -> serial_out=1 next cycle. Next accepted byte 8'h55 transmits cleanly.
- Parity: with UART_TX_PARITY_EN defined, send 8'h07 -> parity symbol=1, frame 11 symbols, data_in_ready after 4774 cycles.
